// File: rtl/rtc_bcd_countdown.sv
// Six-digit BCD countdown (mm:ss:cc) for the stopwatch timer mode.
// Loads a validated BCD preset and counts down one centisecond per basetick.
// Flags expiry at 00:00:00, and can optionally reload the preset and keep going.
//
// state | meaning
// IDLE  | stopped; loads accepted; start runs if count != 0
// RUN   | decrementing on each basetick
// PAUSE | frozen mid-run; start resumes, stop returns to IDLE
// DONE  | expired; count holds 0 until stop or load
module rtc_bcd_countdown #(
  parameter logic [23:0] DIGIT_MAX   = 24'h595999,
  parameter logic        AUTO_RELOAD = 1'b0
) (
  input  logic        i_rtcclk,
  input  logic        i_reset_n,
  input  logic        i_basetick,
  input  logic        i_load,
  input  logic [23:0] i_preset,
  input  logic        i_start,
  input  logic        i_stop,
  output logic [23:0] o_bcdcount,
  output logic [1:0]  o_state,
  output logic        o_expired,
  output logic        o_loaderr
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t      state_q;
  logic [23:0] count_q;
  logic [23:0] preset_q;
  logic [23:0] dec_count;
  logic        preset_ok;
  logic        count_nz;

  // One BCD step down: a zero digit wraps to its maximum and borrows upward.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = DIGIT_MAX[i*4 +: 4];
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Every nibble must lie within its digit's range.
  function automatic logic bcd_valid(input logic [23:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (v[i*4 +: 4] > DIGIT_MAX[i*4 +: 4]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Next-count and preset check, shared by every state.
  always_comb begin
    dec_count = bcd_dec(count_q);
    preset_ok = bcd_valid(i_preset);
    count_nz  = (count_q != 24'd0);
  end

  // Control FSM with count, stored preset and pulse outputs; priority stop > start > load.
  always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      count_q   <= 24'd0;
      preset_q  <= 24'd0;
      o_expired <= 1'b0;
      o_loaderr <= 1'b0;
    end else begin
      o_expired <= 1'b0;
      o_loaderr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_stop) begin
            state_q <= IDLE;
          end else if (i_start && count_nz) begin
            state_q <= RUN;
          end else if (i_load) begin
            if (preset_ok) begin
              count_q  <= i_preset;
              preset_q <= i_preset;
            end else begin
              o_loaderr <= 1'b1;
            end
          end
        end
        RUN: begin
          // A tick arriving with stop is still applied; expiry beats PAUSE.
          if (i_basetick && count_nz) begin
            if (dec_count == 24'd0) begin
              o_expired <= 1'b1;
              if (AUTO_RELOAD && (preset_q != 24'd0)) begin
                count_q <= preset_q;
              end else begin
                count_q <= 24'd0;
                state_q <= DONE;
              end
            end else begin
              count_q <= dec_count;
              if (i_stop) state_q <= PAUSE;
            end
          end else if (i_stop) begin
            state_q <= PAUSE;
          end
        end
        PAUSE: begin
          if (i_stop) begin
            state_q <= IDLE;
          end else if (i_start) begin
            state_q <= RUN;
          end else if (i_load) begin
            if (preset_ok) begin
              count_q  <= i_preset;
              preset_q <= i_preset;
              state_q  <= IDLE;
            end else begin
              o_loaderr <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_stop) begin
            state_q <= IDLE;
          end else if (i_load) begin
            if (preset_ok) begin
              count_q  <= i_preset;
              preset_q <= i_preset;
              state_q  <= IDLE;
            end else begin
              o_loaderr <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_bcdcount = count_q;
  assign o_state    = state_q;

endmodule

// File: doc/rtc_bcd_countdown.md
Name: rtc_bcd_countdown

Overview:
- Six-digit BCD countdown timer for the stopwatch's timer mode. Format is mm:ss:cc: minutes 00-59, seconds 00-59, centiseconds 00-99.
- Loaded with a BCD preset, then decremented once per 10 ms basetick. Borrows propagate digit to digit, the inverse of the up-counting rollover chain.
- Sits beside the 24-bit stopwatch counter. It is driven by the same basetick and trigger controls, and its 24-bit BCD output feeds the same display path.
- Flags expiry at 00:00:00.

Parameters:
DIGIT_MAX, 24'h595999, packed per-digit maximum; [23:20] min tens ... [3:0] cs ones; used for borrow reload and preset validation
AUTO_RELOAD, 1'b0, 1 = on expiry reload the last accepted preset and keep running; 0 = stop in DONE

Ports:
i_rtcclk  input  1  system clock
i_reset_n  input  1  asynchronous, active-low reset
i_basetick  input  1  single-cycle 10 ms enable pulse from the timer
i_load  input  1  single-cycle request to load i_preset
i_preset  input  24  BCD preset, same packing as o_bcdcount
i_start  input  1  single-cycle start/resume
i_stop  input  1  single-cycle pause/acknowledge
o_bcdcount  output  24  current BCD count, registered
o_state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
o_expired  output  1  one-cycle pulse when the count reaches zero
o_loaderr  output  1  one-cycle pulse when a load request is rejected

Behaviour:
- Reset (asynchronous, active-low, clock i_rtcclk):
  - o_bcdcount=0, stored preset=0, o_state=IDLE, o_expired=0, o_loaderr=0.
  - Reset asserted mid-RUN aborts immediately; no expiry pulse is issued.
- All outputs are registered. The count changes on the first i_rtcclk edge where i_basetick=1 in RUN, so latency is 1 cycle.
- Preset validation:
  - A preset is valid iff every nibble is <= its DIGIT_MAX nibble.
  - An invalid preset leaves the count and stored preset unchanged and pulses o_loaderr for 1 cycle.
  - A preset of all zeros is valid.
- Decrement, applied only in RUN on i_basetick with count != 0:
  - Digit 0 is decremented first.
  - A digit equal to 0 reloads to its DIGIT_MAX nibble and borrows into the next digit; otherwise it decrements by 1 and stops the borrow.
  - The count never underflows below 00:00:00.
- IDLE:
  - Valid i_load: count=preset and stored preset=preset.
  - i_start with count!=0: go to RUN. i_start with count==0 is ignored.
  - i_stop: no effect.
- RUN:
  - i_basetick decrements the count.
  - If the decrement produces zero: o_expired=1 for that cycle.
    - AUTO_RELOAD=0: go to DONE.
    - AUTO_RELOAD=1: count=stored preset and stay in RUN. A stored preset of 0 goes to DONE instead.
  - i_stop: go to PAUSE.
  - i_load and i_start: ignored, no o_loaderr.
- PAUSE:
  - i_start: go to RUN.
  - i_stop: go to IDLE, count held.
  - Valid i_load: load the preset and go to IDLE.
  - i_basetick: ignored.
- DONE:
  - Count holds 0.
  - i_stop: go to IDLE.
  - Valid i_load: load the preset and go to IDLE.
  - i_start: ignored.
- Simultaneous events:
  - Priority is stop > start > load.
  - In RUN, i_basetick is processed in the same cycle as i_stop, so the tick is never lost.
  - If that tick reaches zero, the expiry transition wins over PAUSE.
  - In IDLE, i_load and i_start in the same cycle: the load is ignored (start wins); start uses the current count.
- o_expired and o_loaderr are never asserted for more than 1 cycle per event.

Test Plan:
- Reset, load 24'h000003, start, 3 basetick pulses -> count 000002, 000001, 000000; o_expired high exactly 1 cycle on the third tick; o_state=DONE.
- Load 24'h010000, start, 1 tick -> count 24'h005999 (minute borrow reloads sec tens 5, sec ones 9, cs 99).
- Load 24'h006000 -> o_loaderr pulse; count and stored preset unchanged; o_state stays IDLE.
- Load 24'h000100, start, 10 ticks, stop, 5 ticks, start, 1 tick -> count 000090 at pause, held at 000090 during pause, then 000089.
- AUTO_RELOAD=1, load 24'h000002, start, 4 ticks -> 000001, 000000 with reload to 000002, 000001, 000000 with reload to 000002; o_expired pulses twice; o_state stays RUN.
- In RUN at 000001, assert i_stop and i_basetick in the same cycle -> count 000000, o_expired pulse, o_state=DONE (not PAUSE). Separately, reset asserted mid-RUN -> count 0, IDLE, no o_expired.
